// File: rtl/fpu_mult_pkg.sv
// Shared constants and state encoding for the FPU mantissa multiply path.
package fpu_mult_pkg;

  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/AdderSubtractor_24bit.sv
// Ripple-carry adder/subtractor (48 bits wide by default despite the historical
// name). op=0 adds, op=1 subtracts by inverting reg2 and injecting a carry.
module AdderSubtractor_24bit #(
  parameter int W = 48
) (
  input  logic [W-1:0] reg1,
  input  logic [W-1:0] reg2,
  input  logic         op,
  output logic [W-1:0] res,
  output logic         cout
);

  logic [W:0]   carry;
  logic [W-1:0] reg2_x;

  assign carry[0] = op;
  assign reg2_x   = reg2 ^ {W{op}};

  // One full-adder cell per bit, carry rippling from bit 0 upward.
  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign res[gi]     = reg1[gi] ^ reg2_x[gi] ^ carry[gi];
    assign carry[gi+1] = (reg1[gi] & reg2_x[gi]) | (carry[gi] & (reg1[gi] ^ reg2_x[gi]));
  end

  assign cout = carry[W];

endmodule

// File: rtl/mant_mult_seq.sv
// Sequential add-shift mantissa multiplier: one multiplier bit per cycle,
// MANT_W iterations, fixed latency.
//
// Handshake: an operation is accepted on a rising edge where ready=1 and
// start=1 (a and b are sampled on that edge). start is ignored while ready=0.
// done is a single-cycle pulse; product is valid while done=1 and stays stable
// until the next accept or reset.
module mant_mult_seq
  import fpu_mult_pkg::*;
#(
  parameter int MANT_W = fpu_mult_pkg::MANT_W,
  parameter int PROD_W = fpu_mult_pkg::PROD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product,
  output logic [1:0]        dbg_state
);

  mult_state_t       state, state_nxt;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] mcand;
  logic [MANT_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] add_res;
  logic              last_iter;

  assign last_iter = (cnt == CNT_W'(MANT_W - 1));

  // Partial-product accumulation goes through the shared ripple adder;
  // the carry-out is never needed since the product always fits.
  AdderSubtractor_24bit #(
    .W (PROD_W)
  ) u_add (
    .reg1 (acc),
    .reg2 (mcand),
    .op   (1'b0),
    .res  (add_res),
    .cout ()
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one add-shift step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{(PROD_W-MANT_W){1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= add_res;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product   = acc;
  assign dbg_state = state;

endmodule

// File: doc/mant_mult_seq.md
# mant_mult_seq

Sequential 24×24-bit unsigned mantissa multiplier for the FPU multiply path. It produces a 48-bit product by the add-shift method, one multiplier bit per cycle. Each iteration drives its partial-product accumulation through a single 48-bit adder instance. It sits between operand unpacking (hidden bit already restored) and the product normaliser/rounder.

## Interface
- `MANT_W`, default 24: mantissa width, including the hidden bit.
- `PROD_W`, default 48: product width; must equal 2·MANT_W.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to begin a multiply; sampled only when `ready`=1.
- `a` in MANT_W: multiplicand, captured on the accept edge.
- `b` in MANT_W: multiplier, captured on the accept edge.
- `ready` out 1: high only in IDLE.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse; `product` is valid while it is high.
- `product` out PROD_W: final product; held stable until the next accept or reset.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `ready`=1.
  - On `start`=1 at an edge (the accept edge): `mcand` ← zero-extended `a`, `mplier` ← `b`, `acc` ← 0, `cnt` ← 0; go to RUN.
- **RUN**, each edge:
  - If `mplier[0]`=1, `acc` ← adder result; otherwise `acc` is unchanged.
  - `mcand` ← `mcand` << 1 (logical).
  - `mplier` ← `mplier` >> 1 (logical).
  - `cnt` ← `cnt` + 1.
  - When `cnt` = MANT_W−1 at an edge, that edge is the final iteration; go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle; `product` shows `acc`.
  - Next edge returns to IDLE unconditionally.
- Adder inputs are `acc` and `mcand`, with `op`=0 (add). Carry-out is ignored; an unsigned 24×24 product always fits in 48 bits.
- `product` is driven from `acc`. `acc` is only written in RUN or on accept, so `product` keeps the last result through IDLE.
- `start` during RUN or DONE is ignored. It is neither queued nor acknowledged.
- There is no early termination. Latency is fixed, including for zero operands.
- Inputs `a` and `b` are don't-care except on the accept edge.

## Timing
- Reset values: state=IDLE, `ready`=1, `busy`=0, `done`=0, `product`=0. Internal `acc`, `mcand`, `mplier` and `cnt` are also 0.
- Latency: call the accept edge E.
  - RUN iterations occur at edges E+1 … E+24.
  - `done` is high in the cycle after edge E+24 and falls at E+25.
  - `ready` returns high after E+25.
- Throughput: one multiply per 26 cycles when `start` is held high. `ready` is low for 25 cycles per operation.
- `busy` is high from after E through E+24 inclusive.
- Reset mid-operation: on the `rst` edge, return to IDLE with all the reset values above. `done` is never emitted for the aborted operation.
- `rst` and `start` at the same edge: reset wins; the operation is not accepted.
- Critical path: 48-bit ripple add plus mux into `acc`, completed in one cycle.

## Structure
- Shared package `fpu_mult_pkg` holds:
  - `MANT_W` = 24.
  - `PROD_W` = 48.
  - `CNT_W` = 5.
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t`.
- Sub-module: one `AdderSubtractor_24bit` instance, the team's 48-bit ripple adder/subtractor.
  - `reg1`=`acc`, `reg2`=`mcand`, `op`=1'b0, `cout` left unconnected.
- The top level holds the FSM, the counter, the shift registers and the accumulator.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `ready`=1, `busy`=0, `done`=0, `product`=0.
- **Small operands:** `a`=3, `b`=5 accepted at edge E → `done` pulses exactly one cycle after edge E+24, `product`=0x00_0000_000F. `product` stays 0xF in IDLE afterwards.
- **Normalised mantissas and maximum:**
  - `a`=0xC00000, `b`=0x800000 → `product`=0x6000_0000_0000, `product[47]`=0.
  - `a`=`b`=0xFFFFFF → `product`=0xFFFF_FE00_0001.
- **Zero operand:** `a`=0, `b`=0xABCDEF → `product`=0 with the full 24-iteration latency.
- **Ignored start:** pulse `start` with different operands at E+5 and again in the DONE cycle → the first result is unchanged, and there is no second accept until `ready`=1.
- **Reset mid-run:**
  - Assert `rst` at E+10 → no `done` pulse, `product`=0, `ready`=1 the next cycle.
  - A following `a`=7, `b`=9 then gives `product`=63.
